// File: rtl/req_dispatch.sv
// Request capture and dispatch: rising edges on req_in set sticky pending bits,
// and the highest-index unmasked pending line is offered on a registered valid/ready output.
module req_dispatch #(
  parameter  int IN_WIDTH  = 8,
  localparam int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  req_in,
  input  logic [IN_WIDTH-1:0]  mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_idx,
  output logic [IN_WIDTH-1:0]  pending,
  output logic [7:0]           ovf_cnt
);

  // Handshake: out_idx is transferred at a rising edge where out_valid && out_ready
  // (and rst is low). While out_valid is high and out_ready low, out_valid and
  // out_idx hold. A new index may be loaded in the same edge that completes a transfer.

  logic [IN_WIDTH-1:0]  req_d;
  logic [IN_WIDTH-1:0]  rise;
  logic [IN_WIDTH-1:0]  elig;
  logic [IN_WIDTH-1:0]  clr;
  logic [OUT_WIDTH-1:0] sel;
  logic                 load;
  logic                 ovf_hit;

  assign rise = req_in & ~req_d;
  assign elig = pending & mask;

  // Ascending scan so the last (highest) eligible index overrides lower ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (elig[i]) sel = OUT_WIDTH'(i);
    end
  end

  assign load    = (!out_valid || out_ready) && (|elig);
  assign clr     = load ? (IN_WIDTH'(1) << sel) : '0;
  assign ovf_hit = |(rise & pending & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d     <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ovf_cnt   <= '0;
    end else begin
      req_d   <= req_in;
      // A rise in the same cycle as its clear keeps the bit pending.
      pending <= (pending & ~clr) | rise;
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovf_hit && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_req_dispatch.sv
// Bench for req_dispatch: directed scenarios plus random traffic, checked against
// a per-cycle behavioural model and a scoreboard of expected dispatched indices.
module tb_req_dispatch;

  localparam int W  = 8;
  localparam int OW = 3;

  logic          clk;
  logic          rst;
  logic [W-1:0]  req_in;
  logic [W-1:0]  mask;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_idx;
  logic [W-1:0]  pending;
  logic [7:0]    ovf_cnt;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  logic [OW-1:0] exp_q[$];

  // behavioural model state
  bit m_req_d[W];
  bit m_pend[W];
  bit m_valid;
  int m_idx;
  int m_cnt;

  req_dispatch #(.IN_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .pending(pending), .ovf_cnt(ovf_cnt)
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pend_vec();
    int v = 0;
    for (int i = 0; i < W; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  // Reference model: pending lines are a set; the largest eligible member is
  // taken whenever the output slot is free or being emptied.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin m_req_d[i] = 0; m_pend[i] = 0; end
      m_valid = 0; m_idx = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      int  pick;
      bit  repeat_hit;
      bit  slot_free;
      pick = -1;
      for (int i = W - 1; i >= 0; i--)
        if (pick < 0 && m_pend[i] && mask[i]) pick = i;
      slot_free = !m_valid || out_ready;
      if (!slot_free) pick = -1;
      repeat_hit = 0;
      for (int i = 0; i < W; i++) begin
        bit rose;
        rose = req_in[i] && !m_req_d[i];
        if (rose && m_pend[i] && i != pick) repeat_hit = 1;
        if (i == pick) m_pend[i] = 0;
        if (rose) m_pend[i] = 1;
        m_req_d[i] = req_in[i];
      end
      if (pick >= 0) begin
        m_valid = 1; m_idx = pick;
        exp_q.push_back(OW'(pick));
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (repeat_hit && m_cnt < 255) m_cnt++;
    end
  end

  // Monitor: state checks every cycle, scoreboard pop on each accepted transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("pending", int'(pending), model_pend_vec());
      check("ovf_cnt", int'(ovf_cnt), m_cnt);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("dispatch_unexpected", int'(out_idx), -1);
        end else begin
          logic [OW-1:0] e;
          e = exp_q.pop_front();
          check("dispatch_idx", int'(out_idx), int'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic toggle_bit2(input int n);
    for (int k = 0; k < n; k++) begin
      req_in[2] = 1'b1; step(1);
      req_in[2] = 1'b0; step(1);
    end
  endtask

  initial begin
    rst = 1; req_in = '0; mask = 8'hFF; out_ready = 1;
    step(2);
    mon_en = 1;
    rst = 0;
    step(3);
    check("reset_valid", int'(out_valid), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_ovf", int'(ovf_cnt), 0);
    check("reset_idx", int'(out_idx), 0);

    // three simultaneous requests, dispatched descending
    req_in = 8'h2A; step(1);
    check("multi_pending", int'(pending), 8'h2A);
    check("multi_valid0", int'(out_valid), 0);
    step(1); check("multi_idx5", int'(out_idx), 5); check("multi_valid5", int'(out_valid), 1);
    step(1); check("multi_idx3", int'(out_idx), 3);
    step(1); check("multi_idx1", int'(out_idx), 1); check("multi_drained", int'(pending), 0);
    step(1); check("multi_done", int'(out_valid), 0);
    req_in = '0; step(1);

    // backpressure holds the offered index
    out_ready = 0; req_in = 8'h40; step(2);
    check("bp_idx6", int'(out_idx), 6);
    req_in = 8'hC0; step(1);
    check("bp_pending", int'(pending), 8'h80);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_idx", int'(out_idx), 6);
      step(1);
    end
    out_ready = 1; step(1);
    check("bp_next_idx7", int'(out_idx), 7);
    check("bp_next_valid", int'(out_valid), 1);
    step(1); check("bp_done", int'(out_valid), 0);
    req_in = '0; step(1);

    // masked line stays pending until unmasked
    mask = 8'h0F; req_in = 8'h10; step(2);
    check("mask_pending", int'(pending), 8'h10);
    check("mask_blocked", int'(out_valid), 0);
    mask = 8'hFF; step(1);
    check("mask_idx4", int'(out_idx), 4);
    check("mask_valid", int'(out_valid), 1);
    req_in = '0; step(2);

    // overflow counting and saturation
    mask = 8'h00;
    toggle_bit2(3);
    check("ovf_pending", int'(pending), 8'h04);
    check("ovf_two", int'(ovf_cnt), 2);
    toggle_bit2(300);
    check("ovf_sat", int'(ovf_cnt), 255);
    mask = 8'hFF; step(3);

    // reset in the middle of a held transfer
    out_ready = 0; req_in = 8'h01; step(2);
    req_in = 8'hF1; step(1);
    check("midrst_pre_pending", int'(pending), 8'hF0);
    check("midrst_pre_valid", int'(out_valid), 1);
    rst = 1; step(1);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_pending", int'(pending), 0);
    check("midrst_idx", int'(out_idx), 0);
    check("midrst_ovf", int'(ovf_cnt), 0);
    rst = 0; step(1);
    check("midrst_restore", int'(pending), 8'hF1);
    check("midrst_restore_valid", int'(out_valid), 0);
    step(1);
    check("midrst_valid_back", int'(out_valid), 1);
    check("midrst_idx7", int'(out_idx), 7);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 3) == 0) req_in[i] = ~req_in[i];
      mask      = ($urandom_range(0, 2) == 0) ? 8'hFF : W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step(1);
    end

    // drain
    rst = 0; req_in = '0; mask = 8'hFF; out_ready = 1;
    step(20);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_dispatch.md
# req_dispatch

Request-capture and dispatch stage that sits directly upstream of the priority encoder in the request path. It converts level request lines into sticky pending bits on rising edges and selects the highest-index unmasked pending line, encoder rule. It presents that line's index through a registered valid/ready handshake. Serviced bits clear automatically, and lost re-requests are counted.

## Interface
- IN_WIDTH, 8, number of request lines (≥2)
- OUT_WIDTH, $clog2(IN_WIDTH), localparam, index width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_in  in  IN_WIDTH  level request lines, one per source, synchronous to clk
- mask  in  IN_WIDTH  1 = line eligible for dispatch, 0 = held pending
- out_valid  out  1  out_idx holds a dispatched request
- out_ready  in  1  consumer accepts out_idx this cycle
- out_idx  out  OUT_WIDTH  dispatched line index
- pending  out  IN_WIDTH  current pending register, registered
- ovf_cnt  out  8  saturating count of re-requests on already-pending lines

## Operation
- Edge detect: req_d is a registered copy of req_in. rise = req_in & ~req_d.
- Selection:
  - elig = pending & mask, using registered pending only; no bypass from rise.
  - sel = index of highest set bit of elig. Highest index wins.
- Load condition: load = (!out_valid || out_ready) && |elig.
- On load:
  - out_idx <= sel, out_valid <= 1.
  - clr = one-hot(sel); otherwise clr = 0.
- If !load && out_valid && out_ready: out_valid <= 0. out_idx keeps its last value.
- Pending update: pending <= (pending & ~clr) | rise.
  - If a bit is set and cleared in the same cycle, the set wins and the bit stays pending.
- Overflow: ovf_cnt increments by 1 in a cycle where any bit has rise & pending & ~clr.
  - Multiple bits in one cycle count once.
  - ovf_cnt saturates at 255 and does not wrap.
- Mask:
  - Masking only blocks selection. Masked bits still capture rises and stay pending.
  - A masked-off line already in out_idx is still delivered.
- Output stability: while out_valid && !out_ready, out_idx and out_valid do not change, regardless of req_in or mask.
- Back-to-back: with out_ready held 1 and several pending bits, one index is dispatched per cycle, descending.

## Timing
- Reset values after rst = 1 at an edge:
  - req_d = 0, pending = 0, out_valid = 0, out_idx = 0, ovf_cnt = 0.
- Lines already high when rst deasserts register as rises on the first edge after reset.
- rst = 1 mid-transfer drops the in-flight index and all pending bits. No handshake completes on a reset edge.
- Latency from req_in going high before edge E0, output idle:
  - pending bit set after E0.
  - out_valid = 1 with out_idx after E1, so 2 cycles.
- A handshake completes at an edge where out_valid && out_ready. The next index may appear in the same edge's update.
- All outputs are registers. There is no combinational path from req_in, mask or out_ready to any output.

## Test plan
- Reset release with req_in = 8'h00:
  - hold 3 cycles -> out_valid = 0, pending = 0, ovf_cnt = 0.
- Raise req_in bits 1, 5 and 3 together with mask = 8'hFF and out_ready = 1:
  - -> pending = 8'h2A after E0.
  - out_idx 5, 3, 1 on consecutive cycles from E1.
  - out_valid drops after the third accept, and pending = 8'h00.
- Backpressure: req_in[6] rises with out_ready = 0:
  - -> out_valid = 1, out_idx = 6, held constant for 10 cycles.
  - Meanwhile req_in[7] rises, giving pending = 8'h80.
  - After out_ready = 1 for 1 cycle -> out_idx = 7 next.
- Mask: mask = 8'h0F with req_in[4] rising:
  - -> pending[4] = 1, out_valid stays 0.
  - Set mask = 8'hFF -> out_idx = 4 one cycle later.
- Overflow: mask = 8'h00, toggle req_in[2] 0/1 three times:
  - -> pending = 8'h04, ovf_cnt = 2.
  - Toggle 300 times -> ovf_cnt = 255, no wrap.
- Reset mid-operation: out_valid = 1, pending = 8'hF0, then rst pulsed 1 cycle:
  - -> after the edge, all outputs = 0.
  - Lines still high -> pending restored 1 cycle later, out_valid 1 cycle after that.
